// File: rtl/fifo1_rr_scheduler_pkg.sv
// Shared types and defaults for the round-robin one-entry scheduler.
// Consumers import fifo1_sched_pkg::*.
package fifo1_sched_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 32;
    localparam int CNTW_DEF  = 16;

    // Source-tag width: at least one bit even for a single requester.
    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [idw(NREQ_DEF)-1:0] src_id_t;
    typedef logic [WIDTH_DEF-1:0]     word_t;

endpackage

// File: rtl/fifo1_rr_scheduler_rr_grant.sv
// Combinational round-robin grant: first valid requester at or after ptr.
// Produces a one-hot grant and its encoded index.
module rr_grant
    import fifo1_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = idw(NREQ_DEF)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  ptr,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    logic found;
    int   j;

    // Scan ptr, ptr+1, ... mod NREQ and take the first valid requester.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (enable && !found && req_valid[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/fifo1_rr_scheduler.sv
// One-entry buffer shared by NREQ producers with round-robin grant,
// source tagging, per-source accept counters and a sticky protocol flag.
module fifo1_rr_scheduler
    import fifo1_sched_pkg::*;
#(
    parameter  int NREQ  = NREQ_DEF,
    parameter  int WIDTH = WIDTH_DEF,
    parameter  int CNTW  = CNTW_DEF,
    localparam int IDW   = idw(NREQ)
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       enq__RDY,
    input  logic [NREQ-1:0]       enq__ENA,
    input  logic [NREQ*WIDTH-1:0] enq_v,
    output logic                  deq__RDY,
    input  logic                  deq__ENA,
    output logic                  first__RDY,
    output logic [WIDTH-1:0]      first,
    output logic [IDW-1:0]        first_src,
    output logic                  notEmpty,
    output logic                  proto_err,
    input  logic [IDW-1:0]        sel_cnt,
    output logic [CNTW-1:0]       acc_cnt
);

    logic             full;
    logic             err;
    logic [WIDTH-1:0] element;
    logic [IDW-1:0]   src;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   gidx;
    logic [NREQ-1:0]  grant;
    logic [CNTW-1:0]  cnt [NREQ];
    logic             enq_ok;
    logic             enq_err;
    logic             deq_ok;
    logic             deq_err;

    rr_grant #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_grant (
        .req_valid (req_valid),
        .ptr       (ptr),
        .enable    (!full),
        .grant     (grant),
        .idx       (gidx)
    );

    // Classify this cycle's enq/deq as legal or a protocol violation.
    always_comb begin
        enq_ok  = 1'b0;
        enq_err = 1'b0;
        deq_ok  = 1'b0;
        deq_err = 1'b0;
        if (enq__ENA != '0) begin
            enq_ok  = (enq__ENA == grant);
            enq_err = !enq_ok;
        end
        deq_ok  = deq__ENA && full;
        deq_err = deq__ENA && !full;
    end

    // Control state: full flag, priority pointer, counters, error flag.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            full <= 1'b0;
            ptr  <= '0;
            err  <= 1'b0;
            for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
        end else begin
            if (enq_ok) begin
                full      <= 1'b1;
                ptr       <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + IDW'(1);
                cnt[gidx] <= cnt[gidx] + CNTW'(1);
            end else if (deq_ok) begin
                full <= 1'b0;
            end
            if (enq_err || deq_err) err <= 1'b1;
        end
    end

    // Payload and tag are captured on accept only; don't-care while empty.
    always_ff @(posedge CLK) begin
        if (enq_ok) begin
            element <= enq_v[int'(gidx)*WIDTH +: WIDTH];
            src     <= gidx;
        end
    end

    // Debug counter readout; out-of-range selects read as zero.
    always_comb begin
        acc_cnt = '0;
        if (int'(sel_cnt) < NREQ) acc_cnt = cnt[sel_cnt];
    end

    assign enq__RDY   = grant;
    assign deq__RDY   = full;
    assign first__RDY = full;
    assign notEmpty   = full;
    assign first      = element;
    assign first_src  = src;
    assign proto_err  = err;

endmodule

// File: tb/tb_fifo1_rr_scheduler.sv
// Self-checking bench for fifo1_rr_scheduler against a queue-level model.
// A second instance with 4-bit counters exercises counter wrap.
module tb_fifo1_rr_scheduler;

    logic         CLK;
    logic         nRST;
    logic [3:0]   req_valid, ena;
    logic [127:0] enq_v;
    logic         deq;
    logic [1:0]   sel_cnt;
    logic [3:0]   enq_rdy;
    logic         deq_rdy, first_rdy, not_empty, proto_err;
    logic [31:0]  first;
    logic [1:0]   first_src;
    logic [15:0]  acc_cnt;

    logic [3:0]   req4, ena4, rdy4;
    logic         deq4, deqrdy4, firstrdy4, ne4, err4;
    logic [1:0]   sel4, src4;
    logic [31:0]  first4;
    logic [3:0]   acc4;

    int cmp = 0;
    int mis = 0;

    bit          m_full;
    bit          m_err;
    logic [31:0] m_elem;
    int          m_src;
    int          m_ptr;
    int          m_cnt [4];

    fifo1_rr_scheduler dut (
        .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .enq__RDY(enq_rdy),
        .enq__ENA(ena), .enq_v(enq_v), .deq__RDY(deq_rdy), .deq__ENA(deq),
        .first__RDY(first_rdy), .first(first), .first_src(first_src),
        .notEmpty(not_empty), .proto_err(proto_err), .sel_cnt(sel_cnt),
        .acc_cnt(acc_cnt)
    );

    fifo1_rr_scheduler #(.CNTW(4)) dut4 (
        .CLK(CLK), .nRST(nRST), .req_valid(req4), .enq__RDY(rdy4),
        .enq__ENA(ena4), .enq_v(enq_v), .deq__RDY(deqrdy4), .deq__ENA(deq4),
        .first__RDY(firstrdy4), .first(first4), .first_src(src4),
        .notEmpty(ne4), .proto_err(err4), .sel_cnt(sel4), .acc_cnt(acc4)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Expected grant: first requester with req_valid scanning from m_ptr.
    function automatic logic [3:0] exp_grant();
        if (m_full) return 4'b0;
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (m_ptr + k) % 4;
            if (req_valid[j]) return 4'(1 << j);
        end
        return 4'b0;
    endfunction

    // Advance one clock, applying the queue-level rules to the model.
    task automatic tick();
        logic [3:0] g;
        bit         f;
        int         idx;
        @(posedge CLK);
        if (!nRST) begin
            m_full = 0;
            m_ptr  = 0;
            m_err  = 0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else begin
            g = exp_grant();
            f = m_full;
            if (ena != 4'b0) begin
                if (ena == g) begin
                    idx = 0;
                    for (int i = 0; i < 4; i++) if (g[i]) idx = i;
                    m_elem     = enq_v[idx*32 +: 32];
                    m_src      = idx;
                    m_full     = 1;
                    m_ptr      = (idx + 1) % 4;
                    m_cnt[idx] = (m_cnt[idx] + 1) % 65536;
                end else begin
                    m_err = 1;
                end
            end
            if (deq) begin
                if (f) m_full = 0;
                else m_err = 1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
    endtask

    task automatic rand_data();
        enq_v = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic test_reset();
        req_valid = 0; ena = 0; deq = 0;
        do_reset();
        tick();
        for (int s = 0; s < 4; s++) begin
            sel_cnt = 2'(s);
            #1;
            cmp++;
            if (acc_cnt !== 16'd0) begin
                mis++;
                $display("FAIL reset_acc_cnt sel=%0d: got %0d want 0", s, acc_cnt);
            end
        end
        cmp++;
        if ({not_empty, deq_rdy, first_rdy, proto_err} !== 4'b0) begin
            mis++;
            $display("FAIL reset_flags: got %b want 0000",
                     {not_empty, deq_rdy, first_rdy, proto_err});
        end
        cmp++;
        if (enq_rdy !== 4'b0) begin
            mis++;
            $display("FAIL reset_enq_rdy: got %b want 0000", enq_rdy);
        end
        req_valid = 4'b0100; ena = 4'b0100; rand_data();
        tick();
        ena = 0;
        cmp++;
        if (not_empty !== 1'b1) begin
            mis++;
            $display("FAIL pre_reset_full: got %b want 1", not_empty);
        end
        do_reset();
        req_valid = 0;
        cmp++;
        if ({not_empty, deq_rdy} !== 2'b00) begin
            mis++;
            $display("FAIL mid_reset_discard: got %b want 00", {not_empty, deq_rdy});
        end
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0010;
        #1;
        cmp++;
        if (enq_rdy !== 4'b0010) begin
            mis++;
            $display("FAIL single_grant: got %b want 0010", enq_rdy);
        end
        ena = 4'b0010;
        rand_data();
        enq_v[63:32] = 32'hDEADBEEF;
        tick();
        ena = 0;
        cmp++;
        if ({not_empty, first, first_src, enq_rdy} !== {1'b1, 32'hDEADBEEF, 2'd1, 4'b0}) begin
            mis++;
            $display("FAIL single_enq: got ne=%b d=%h s=%0d rdy=%b want 1 deadbeef 1 0000",
                     not_empty, first, first_src, enq_rdy);
        end
        deq = 1;
        tick();
        deq = 0;
        req_valid = 4'b1111;
        #1;
        cmp++;
        if ({not_empty, enq_rdy} !== {1'b0, 4'b0100}) begin
            mis++;
            $display("FAIL single_deq_ptr: got ne=%b rdy=%b want 0 0100", not_empty, enq_rdy);
        end
    endtask

    task automatic test_round_robin();
        int n;
        n = 0;
        do_reset();
        req_valid = 4'b1111;
        for (int c = 0; c < 16; c++) begin
            rand_data();
            ena = exp_grant();
            deq = m_full;
            #1;
            if (not_empty) begin
                cmp++;
                if (first_src !== 2'(n % 4) || first !== m_elem) begin
                    mis++;
                    $display("FAIL rr_order word %0d: got src=%0d d=%h want src=%0d d=%h",
                             n, first_src, first, n % 4, m_elem);
                end
                n++;
            end
            tick();
        end
        ena = 0; deq = 0; req_valid = 0;
        cmp++;
        if (n !== 8) begin
            mis++;
            $display("FAIL rr_throughput: got %0d words want 8", n);
        end
        for (int s = 0; s < 4; s++) begin
            sel_cnt = 2'(s);
            #1;
            cmp++;
            if (acc_cnt !== 16'd2) begin
                mis++;
                $display("FAIL rr_acc_cnt sel=%0d: got %0d want 2", s, acc_cnt);
            end
        end
    endtask

    task automatic test_wrap_hold();
        do_reset();
        req_valid = 4'b0100; ena = 4'b0100; rand_data();
        tick();
        ena = 0; deq = 1;
        tick();
        deq = 0;
        req_valid = 4'b0101;
        #1;
        cmp++;
        if (enq_rdy !== 4'b0001) begin
            mis++;
            $display("FAIL wrap_grant: got %b want 0001", enq_rdy);
        end
        ena = 4'b0001;
        tick();
        ena = 0; deq = 1;
        tick();
        deq = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            cmp++;
            if (enq_rdy !== 4'b0100) begin
                mis++;
                $display("FAIL hold_grant cycle %0d: got %b want 0100", c, enq_rdy);
            end
            tick();
        end
        ena = 4'b0100; rand_data();
        tick();
        ena = 0;
        cmp++;
        if ({not_empty, first_src} !== {1'b1, 2'd2}) begin
            mis++;
            $display("FAIL hold_accept: got ne=%b s=%0d want 1 2", not_empty, first_src);
        end
        deq = 1;
        tick();
        deq = 0; req_valid = 0;
    endtask

    task automatic test_proto_err();
        logic [31:0] held;
        do_reset();
        req_valid = 4'b0001; ena = 4'b0001; rand_data();
        held = enq_v[31:0];
        tick();
        ena = 4'b1000; rand_data();
        tick();
        ena = 4'b0011;
        tick();
        ena = 0;
        sel_cnt = 2'd3;
        #1;
        cmp++;
        if ({proto_err, not_empty, first, first_src, acc_cnt} !== {1'b1, 1'b1, held, 2'd0, 16'd0}) begin
            mis++;
            $display("FAIL bad_enq: got e=%b ne=%b d=%h s=%0d c3=%0d want 1 1 %h 0 0",
                     proto_err, not_empty, first, first_src, acc_cnt, held);
        end
        deq = 1;
        tick();
        tick();
        deq = 0;
        sel_cnt = 2'd0;
        #1;
        cmp++;
        if ({proto_err, not_empty, acc_cnt} !== {1'b1, 1'b0, 16'd1}) begin
            mis++;
            $display("FAIL bad_deq: got e=%b ne=%b c0=%0d want 1 0 1",
                     proto_err, not_empty, acc_cnt);
        end
        req_valid = 4'b0010; ena = 4'b0010;
        tick();
        ena = 0; deq = 1;
        tick();
        deq = 0; req_valid = 0;
        cmp++;
        if (proto_err !== 1'b1) begin
            mis++;
            $display("FAIL err_sticky: got %b want 1", proto_err);
        end
    endtask

    task automatic test_random();
        int r;
        logic [3:0] g;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            nRST = (c % 150 == 149) ? 1'b0 : 1'b1;
            req_valid = 4'($urandom);
            rand_data();
            g = exp_grant();
            r = $urandom_range(0, 39);
            if (r < 26) ena = g;
            else if (r == 39) ena = 4'($urandom);
            else ena = 0;
            deq = m_full ? 1'($urandom) : (r == 38);
            sel_cnt = 2'($urandom);
            #1;
            cmp++;
            if (enq_rdy !== g || not_empty !== m_full || deq_rdy !== m_full ||
                first_rdy !== m_full || proto_err !== m_err ||
                acc_cnt !== 16'(m_cnt[sel_cnt])) begin
                mis++;
                $display("FAIL rand_ctl cyc %0d: got rdy=%b ne=%b e=%b c=%0d want %b %b %b %0d",
                         c, enq_rdy, not_empty, proto_err, acc_cnt,
                         g, m_full, m_err, m_cnt[sel_cnt]);
            end
            if (m_full) begin
                cmp++;
                if (first !== m_elem || first_src !== 2'(m_src)) begin
                    mis++;
                    $display("FAIL rand_data cyc %0d: got %h/%0d want %h/%0d",
                             c, first, first_src, m_elem, m_src);
                end
            end
            tick();
        end
        nRST = 1; ena = 0; deq = 0; req_valid = 0;
    endtask

    task automatic test_cnt_wrap();
        do_reset();
        req4 = 4'b0001;
        for (int n = 1; n <= 16; n++) begin
            ena4 = 4'b0001;
            tick();
            ena4 = 0; deq4 = 1;
            tick();
            deq4 = 0;
            #1;
            cmp++;
            if (acc4 !== 4'(n % 16)) begin
                mis++;
                $display("FAIL cnt_wrap n=%0d: got %0d want %0d", n, acc4, n % 16);
            end
        end
        req4 = 0;
        cmp++;
        if ({err4, ne4} !== 2'b00) begin
            mis++;
            $display("FAIL cnt_wrap_flags: got %b want 00", {err4, ne4});
        end
    endtask

    initial begin
        nRST = 0; req_valid = 0; ena = 0; deq = 0; sel_cnt = 0; enq_v = '0;
        req4 = 0; ena4 = 0; deq4 = 0; sel4 = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap_hold();
        test_proto_err();
        test_random();
        test_cnt_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end

endmodule
